// File: rtl/spi_pts_pkg.sv
// Shared types and sizing helpers for the spi_pts_tx MISO serialiser.
package spi_pts_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pts_state_t;

  localparam int WORD_CNT_W = 16;

  // Width of a counter that must hold the values 0..data_w inclusive.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/pts_hold_buf.sv
// One-entry valid/ready holding buffer; a pop with the buffer empty takes the
// incoming write directly (bypass) so the word never lands in the buffer.
module pts_hold_buf #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              wr_fire;

  always_comb begin
    wr_fire    = wr_valid && !hold_vld_q;
    out_valid  = hold_vld_q || wr_fire;
    out_data   = hold_vld_q ? hold_q : wr_data;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (pop && hold_vld_q) begin
      hold_vld_d = 1'b0;
    end else if (wr_fire && !pop) begin
      hold_vld_d = 1'b1;
      hold_d     = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign wr_ready = !hold_vld_q;

endmodule

// File: rtl/spi_pts_tx.sv
// SPI slave MISO serialiser with a one-word holding buffer and underrun flag.
// Optional PTS_WORD_COUNT_EN adds a saturating per-frame completed-word counter.
module spi_pts_tx
  import spi_pts_pkg::*;
#(
  parameter int   DATA_W    = 12,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              shift_pulse,
  input  logic              clr_underrun,
  output logic              miso,
  output logic              busy,
  output logic              underrun
`ifdef PTS_WORD_COUNT_EN
  ,output logic [WORD_CNT_W-1:0] word_count
`endif
);

  localparam int              CW       = cnt_w(DATA_W);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_W);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [DATA_W-1:0] FILL   = {DATA_W{IDLE_VAL}};

  pts_state_t        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              underrun_q, underrun_d;
  logic              reload, start_frame, word_done;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;

  pts_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .pop      (reload),
    .out_valid(buf_valid),
    .out_data (buf_data)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    underrun_d  = underrun_q && !clr_underrun;
    reload      = 1'b0;
    start_frame = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start && !frame_end) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
          reload      = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          state_d = IDLE;
          sr_d    = FILL;
          cnt_d   = '0;
        end else if (shift_pulse) begin
          if (cnt_q > CNT_ONE) begin
            sr_d  = MSB_FIRST ? {sr_q[DATA_W-2:0], IDLE_VAL} : {IDLE_VAL, sr_q[DATA_W-1:1]};
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            word_done = 1'b1;
            reload    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload comes after the clear so a fresh underrun wins over clr_underrun.
    if (reload) begin
      cnt_d = CNT_FULL;
      if (buf_valid) begin
        sr_d = buf_data;
      end else begin
        sr_d       = FILL;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= FILL;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef PTS_WORD_COUNT_EN
  logic [WORD_CNT_W-1:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (start_frame) begin
      word_count_d = '0;
    end else if (word_done && (word_count_q != {WORD_CNT_W{1'b1}})) begin
      word_count_d = word_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`else
  logic unused_ok;
  assign unused_ok = start_frame ^ word_done;
`endif

  assign miso     = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
  assign busy     = (state_q == ACTIVE);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_pts_tx.sv
// Self-checking bench for spi_pts_tx: MSB-first and LSB-first instances share
// one stimulus stream and are compared against a word-level reference model.
module tb_spi_pts_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_data = '0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        shift_pulse = 1'b0;
  logic        clr_underrun = 1'b0;

  logic wr_ready_m, miso_m, busy_m, underrun_m;
  logic wr_ready_l, miso_l, busy_l, underrun_l;

  int checks = 0;
  int errors = 0;

  // Reference model state: a whole word plus how many of its bits have gone out.
  logic        m_active = 1'b0;
  logic        m_hold_vld = 1'b0;
  logic [11:0] m_hold = '0;
  logic        m_loaded = 1'b0;
  logic [11:0] m_cur = '0;
  int          m_pos = 0;
  logic        m_underrun = 1'b0;

  always #5 clk = ~clk;

  spi_pts_tx #(.DATA_W(12), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_m),
    .frame_start(frame_start), .frame_end(frame_end), .shift_pulse(shift_pulse),
    .clr_underrun(clr_underrun), .miso(miso_m), .busy(busy_m), .underrun(underrun_m)
  );

  spi_pts_tx #(.DATA_W(12), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_l),
    .frame_start(frame_start), .frame_end(frame_end), .shift_pulse(shift_pulse),
    .clr_underrun(clr_underrun), .miso(miso_l), .busy(busy_l), .underrun(underrun_l)
  );

  task automatic cmp(input string name, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmpWord(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    logic accept;
    accept = wr_valid && !m_hold_vld;
    if (rst) begin
      m_active = 0; m_hold_vld = 0; m_loaded = 0; m_pos = 0; m_underrun = 0;
      return;
    end
    m_underrun = m_underrun && !clr_underrun;
    if (m_active) begin
      if (frame_end) begin
        m_active = 0;
        m_loaded = 0;
      end else if (shift_pulse) begin
        if (m_pos < 11) m_pos++;
        else modelReload(accept);
      end
    end else if (frame_start && !frame_end) begin
      m_active = 1;
      modelReload(accept);
    end
    if (accept) begin
      m_hold_vld = 1;
      m_hold     = wr_data;
    end
  endtask

  task automatic modelReload(inout logic accept);
    m_loaded = 1;
    m_pos    = 0;
    if (m_hold_vld) begin
      m_cur      = m_hold;
      m_hold_vld = 0;
    end else if (accept) begin
      m_cur  = wr_data;
      accept = 0;
    end else begin
      m_cur      = 12'hFFF;
      m_underrun = 1;
    end
  endtask

  task automatic checkOutput();
    logic exp_m, exp_l;
    exp_m = m_loaded ? m_cur[11 - m_pos] : 1'b1;
    exp_l = m_loaded ? m_cur[m_pos] : 1'b1;
    cmp("miso_msb", miso_m, exp_m);
    cmp("miso_lsb", miso_l, exp_l);
    cmp("busy", busy_m, m_active);
    cmp("busy_lsb", busy_l, m_active);
    cmp("wr_ready", wr_ready_m, !m_hold_vld);
    cmp("wr_ready_lsb", wr_ready_l, !m_hold_vld);
    cmp("underrun", underrun_m, m_underrun);
    cmp("underrun_lsb", underrun_l, m_underrun);
  endtask

  task automatic applyStimulus(input logic fs, input logic fe, input logic sp, input logic wv,
                               input logic [11:0] wd, input logic clr, input logic r);
    frame_start = fs; frame_end = fe; shift_pulse = sp; wr_valid = wv;
    wr_data = wd; clr_underrun = clr; rst = r;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 12'h000, 0, 0);
  endtask

  // Capture nbits serial bits, pulsing shift between them (no pulse after the last).
  task automatic shiftWord(input int nbits, output logic [23:0] mbits, output logic [23:0] lbits);
    mbits = '0;
    lbits = '0;
    for (int i = 0; i < nbits; i++) begin
      mbits[nbits-1-i] = miso_m;
      lbits[i]         = miso_l;
      if (i < nbits - 1) applyStimulus(0, 0, 1, 0, 12'h000, 0, 0);
    end
  endtask

  initial begin
    logic [23:0] mb, lb;

    applyStimulus(0, 0, 0, 0, 12'h000, 0, 1);
    applyStimulus(0, 0, 0, 0, 12'h000, 0, 1);
    cmp("reset_miso", miso_m, 1'b1);
    cmp("reset_ready", wr_ready_m, 1'b1);
    idleCycle();

    // Single word, captured on both bit orders.
    applyStimulus(0, 0, 0, 1, 12'hA5C, 0, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    shiftWord(12, mb, lb);
    cmpWord("a5c_msb_stream", mb, 24'h000A5C);
    cmpWord("a5c_lsb_stream", lb, 24'h000A5C);
    applyStimulus(0, 1, 0, 0, 12'h000, 0, 0);
    cmp("a5c_underrun", underrun_m, 1'b0);
    cmp("a5c_idle_miso", miso_m, 1'b1);

    // LSB-first single low bit.
    applyStimulus(0, 0, 0, 1, 12'h001, 0, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    shiftWord(12, mb, lb);
    cmpWord("w001_lsb_stream", lb, 24'h000001);
    applyStimulus(0, 1, 0, 0, 12'h000, 0, 0);

    // Back-to-back words with no gap between them.
    applyStimulus(0, 0, 0, 1, 12'hFFF, 0, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 0, 1, 12'h000, 0, 0);
    cmp("b2b_ready_low", wr_ready_m, 1'b0);
    shiftWord(24, mb, lb);
    cmpWord("b2b_msb_stream", mb, 24'hFFF000);
    cmpWord("b2b_lsb_stream", lb, 24'h000FFF);
    cmp("b2b_ready_back", wr_ready_m, 1'b1);
    cmp("b2b_no_underrun", underrun_m, 1'b0);
    applyStimulus(0, 1, 0, 0, 12'h000, 0, 0);

    // Underrun, clear, then clear colliding with a fresh underrun.
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    cmp("ur_set", underrun_m, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 0, 0, 12'h000, 1, 0);
    cmp("ur_cleared", underrun_m, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 1, 0, 12'h000, 1, 0);
    cmp("ur_set_beats_clr", underrun_m, 1'b1);
    applyStimulus(0, 1, 0, 0, 12'h000, 1, 0);

    // Frame aborted mid-word; the buffered word goes out in the next frame.
    applyStimulus(0, 0, 0, 1, 12'h800, 0, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 0, 1, 12'h123, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 12'h000, 0, 0);
    applyStimulus(0, 1, 1, 0, 12'h000, 0, 0);
    cmp("abort_miso", miso_m, 1'b1);
    cmp("abort_busy", busy_m, 1'b0);
    idleCycle();
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    shiftWord(12, mb, lb);
    cmpWord("abort_next_word", mb, 24'h000123);
    applyStimulus(0, 1, 0, 0, 12'h000, 0, 0);

    // Reset in the middle of a word with another word buffered.
    applyStimulus(0, 0, 0, 1, 12'hABC, 0, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 1, 1, 12'h456, 0, 0);
    applyStimulus(0, 0, 1, 0, 12'h000, 0, 0);
    applyStimulus(0, 0, 0, 0, 12'h000, 0, 1);
    cmp("rst_miso", miso_m, 1'b1);
    cmp("rst_busy", busy_m, 1'b0);
    cmp("rst_ready", wr_ready_m, 1'b1);
    cmp("rst_underrun", underrun_m, 1'b0);
    idleCycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom % 10) == 0, ($urandom % 45) == 0, ($urandom % 2) == 0,
                    ($urandom % 3) == 0, 12'($urandom), ($urandom % 12) == 0,
                    ($urandom % 300) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_pts_tx.md
Name: spi_pts_tx

Overview:
Parametrised SPI slave transmit serialiser for the MISO path. It generalises the fixed 12-bit shifter with configurable word width and bit order, and adds a one-word holding buffer with a valid/ready write handshake. It sends back-to-back words without gaps and flags underrun. It sits between the core's result producer and the SPI pin logic, and is driven by the existing SCK edge-detect pulse and chip-select frame strobes.

Parameters:
DATA_W, 12, word width in bits (2..32)
MSB_FIRST, 1, 1 = shift MSB out first; 0 = LSB first
IDLE_VAL, 1'b1, fill bit driven on miso when idle or on underrun

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
wr_valid  input  1  producer has a word
wr_data  input  DATA_W  word to transmit
wr_ready  output  1  holding buffer empty; a write is accepted when wr_valid && wr_ready
frame_start  input  1  single-cycle pulse, chip select asserted (already synchronised)
frame_end  input  1  single-cycle pulse, chip select deasserted
shift_pulse  input  1  single-cycle pulse, advance one bit (SCK shift edge)
clr_underrun  input  1  clears the sticky underrun flag
miso  output  1  serial data out
busy  output  1  high while a frame is active
underrun  output  1  sticky: a word boundary was reached with no data available

Behaviour:
- Storage: hold_q/hold_vld (holding buffer), sr_q (shift register, DATA_W bits), cnt_q (bits remaining, $clog2(DATA_W+1) wide), state_q.
- Reset values: state=IDLE, hold_vld=0, sr_q=all IDLE_VAL, cnt_q=0, underrun=0. Therefore miso=IDLE_VAL, busy=0, wr_ready=1.
- miso is taken directly from the registered shift register: sr_q[DATA_W-1] if MSB_FIRST, otherwise sr_q[0]. The output is glitch-free.
- wr_ready = !hold_vld. An accepted write sets hold_vld the next cycle.
- States: IDLE and ACTIVE. busy = (state==ACTIVE).
- IDLE -> ACTIVE on frame_start. The same edge performs a "reload".
- Reload:
  - If hold_vld: sr_q<=hold_q, hold_vld<=0.
  - Else if a write is accepted this same cycle: bypass, sr_q<=wr_data and hold stays empty.
  - Else: sr_q<=all IDLE_VAL and underrun<=1.
  - In every case cnt_q<=DATA_W.
- ACTIVE with shift_pulse:
  - If cnt_q>1: shift by one toward the output end, fill the vacated bit with IDLE_VAL, cnt_q-1.
  - If cnt_q==1: reload. The next word's first bit is on miso the cycle after, with no bubble.
- Latency: the first bit is on miso one clk after frame_start; each subsequent bit appears one clk after its shift_pulse.
- ACTIVE -> IDLE on frame_end: sr_q<=all IDLE_VAL, cnt_q<=0. A partially shifted word is discarded. hold_q is retained for the next frame.
- Simultaneous events:
  - frame_end beats shift_pulse and frame_start in the same cycle.
  - frame_start while already ACTIVE is ignored.
  - shift_pulse in IDLE is ignored.
  - Underrun set beats clr_underrun.
  - A write accepted in the same cycle hold is transferred to sr_q is impossible, since wr_ready=0 while hold_vld.
- rst mid-frame returns every register to its reset value on that edge. Buffered data is lost.

Optional Feature:
Macro PTS_WORD_COUNT_EN.
- Defined: adds output word_count [15:0].
  - Clears to 0 on reset and on frame_start.
  - Increments when a word completes all DATA_W shifts, counting underrun fill words too.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE.
- Not defined: the port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package spi_pts_pkg:
  - pts_state_t enum (IDLE, ACTIVE)
  - localparam function cnt_w(DATA_W)
  - WORD_CNT_W=16
- Sub-module pts_hold_buf (parameter DATA_W): one-entry valid/ready buffer with pop and bypass outputs. The top level contains the FSM, shifter and counter.

Test Plan:
- DATA_W=12, MSB_FIRST=1: write 12'hA5C, frame_start, 12 shift_pulses -> miso sequence 1010_0101_1100, then IDLE_VAL after frame_end; underrun=0.
- MSB_FIRST=0: write 12'h001, frame_start, 12 pulses -> miso 1 then 0 x11 (LSB first).
- Back-to-back: write 12'hFFF, frame_start, write 12'h000 while shifting, 24 pulses -> 12 ones then 12 zeros with no gap; wr_ready returns to 1 the cycle after the second reload.
- Underrun: frame_start with buffer empty -> underrun=1, miso=1 for 12 pulses; clr_underrun -> 0; clr and a new underrun in the same cycle -> stays 1.
- frame_end after 5 pulses of 12'h800 with 12'h123 buffered -> miso=IDLE_VAL, busy=0; next frame sends 12'h123.
- Reset asserted mid-word -> next cycle miso=1, busy=0, wr_ready=1, underrun=0; with PTS_WORD_COUNT_EN defined, word_count=0.
